byte_bank_loader: RTL and testbench

Parametrised byte-wide loader for a wide data word. An 8-bit host path writes into NUM_WORDS slots, either addressed directly or streamed with an auto-incrementing pointer. It tracks which slots are loaded and presents the assembled word to downstream logic through a double-buffered shadow register that only updates on an explicit commit. It also provides registered read-back of any slot. It sits between the host/byte bus and wide-operand datapaths.

---
 rtl/byte_bank_loader.sv | 103 ++++++++++
 tb/tb_byte_bank_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/byte_bank_loader.sv
// Byte-wide loader for a NUM_WORDS x DATA_W working bank, with valid tracking,
// an auto-incrementing stream pointer, registered read-back and a commit-only shadow.
module byte_bank_loader #(
    parameter int DATA_W    = 8,
    parameter int NUM_WORDS = 32,
    parameter int AW        = $clog2(NUM_WORDS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic                        auto_inc,
    input  logic [AW-1:0]               addr,
    input  logic [DATA_W-1:0]           data_i,
    input  logic                        clr,
    input  logic                        commit,
    input  logic [AW-1:0]               rd_addr,
    output logic [DATA_W-1:0]           rd_data,
    output logic [NUM_WORDS*DATA_W-1:0] a,
    output logic [AW-1:0]               ptr,
    output logic [1:0]                  state,
    output logic                        commit_ack
);

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'b00,
        ST_PARTIAL  = 2'b01,
        ST_COMPLETE = 2'b10
    } state_t;

    state_t                        state_q;
    state_t                        state_d;
    logic [DATA_W-1:0]             bank [NUM_WORDS];
    logic [NUM_WORDS-1:0]          valid_q;
    logic [NUM_WORDS-1:0]          valid_d;
    logic [AW-1:0]                 wr_idx;
    logic [NUM_WORDS*DATA_W-1:0]   bank_flat;

    assign wr_idx = auto_inc ? ptr : addr;

    // Next valid mask; clr wins over a same-cycle write.
    always_comb begin
        valid_d = valid_q;
        if (clr) begin
            valid_d = '0;
        end else if (we) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    // Occupancy state follows the next valid mask, so it is current one cycle after a write.
    always_comb begin
        state_d = ST_PARTIAL;
        if (valid_d == '0) begin
            state_d = ST_EMPTY;
        end else if (&valid_d) begin
            state_d = ST_COMPLETE;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_WORDS; k++) begin
            bank_flat[k*DATA_W +: DATA_W] = bank[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                bank[k] <= '0;
            end
        end else if (we) begin
            bank[wr_idx] <= data_i;
        end
    end

    // Shadow, read-back and ack all sample the pre-edge bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            state_q    <= ST_EMPTY;
            ptr        <= '0;
            a          <= '0;
            rd_data    <= '0;
            commit_ack <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            state_q    <= state_d;
            commit_ack <= commit;
            rd_data    <= bank[rd_addr];
            if (commit) begin
                a <= bank_flat;
            end
            if (clr) begin
                ptr <= '0;
            end else if (we && auto_inc) begin
                ptr <= ptr + AW'(1);
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_byte_bank_loader.sv
// Scoreboard bench for byte_bank_loader: a slot-array reference model pushes expected
// outputs per cycle, a monitor pops and compares; a 4x16 instance covers the parameter sweep.
module tb_byte_bank_loader;

    localparam int N  = 32;
    localparam int DW = 8;

    logic           clk = 1'b0;
    logic           rst, we, auto_inc, clr, commit;
    logic [4:0]     addr, rd_addr, ptr;
    logic [7:0]     data_i, rd_data;
    logic [255:0]   a;
    logic [1:0]     state;
    logic           commit_ack;

    logic           rst2, we2, auto_inc2, clr2, commit2;
    logic [1:0]     addr2, rd_addr2, ptr2;
    logic [15:0]    data_i2, rd_data2;
    logic [63:0]    a2;
    logic [1:0]     state2;
    logic           commit_ack2;

    always #5 clk = ~clk;

    byte_bank_loader #(.DATA_W(DW), .NUM_WORDS(N)) dut (
        .clk(clk), .rst(rst), .we(we), .auto_inc(auto_inc), .addr(addr),
        .data_i(data_i), .clr(clr), .commit(commit), .rd_addr(rd_addr),
        .rd_data(rd_data), .a(a), .ptr(ptr), .state(state), .commit_ack(commit_ack)
    );

    byte_bank_loader #(.DATA_W(16), .NUM_WORDS(4)) dut2 (
        .clk(clk), .rst(rst2), .we(we2), .auto_inc(auto_inc2), .addr(addr2),
        .data_i(data_i2), .clr(clr2), .commit(commit2), .rd_addr(rd_addr2),
        .rd_data(rd_data2), .a(a2), .ptr(ptr2), .state(state2), .commit_ack(commit_ack2)
    );

    typedef struct {
        logic [255:0] a;
        logic [7:0]   rd;
        logic [4:0]   ptr;
        logic [1:0]   st;
        logic         ack;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;

    // Reference model: plain slot array, set of loaded slots, stream position, shadow copy.
    logic [7:0]   mem [N];
    bit   [N-1:0] loaded;
    int           mptr;
    logic [255:0] shadow;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, advances the model across the edge and queues the result.
    task automatic step(input bit r, input bit w, input bit ai, input logic [4:0] ad,
                        input logic [7:0] d, input bit c, input bit cm, input logic [4:0] ra);
        exp_t e;
        int   idx;
        rst = r; we = w; auto_inc = ai; addr = ad; data_i = d;
        clr = c; commit = cm; rd_addr = ra;
        if (r) begin
            foreach (mem[k]) mem[k] = '0;
            loaded = '0; mptr = 0; shadow = '0;
            e.rd = '0; e.ack = 1'b0;
        end else begin
            e.rd  = mem[ra];
            e.ack = cm;
            if (cm) for (int k = 0; k < N; k++) shadow[k*8 +: 8] = mem[k];
            if (c) begin
                foreach (mem[k]) mem[k] = '0;
                loaded = '0; mptr = 0;
            end else if (w) begin
                idx = ai ? mptr : int'(ad);
                mem[idx] = d;
                loaded[idx] = 1'b1;
                if (ai) mptr = (mptr + 1) % N;
            end
        end
        e.a   = shadow;
        e.ptr = 5'(mptr);
        if ($countones(loaded) == 0)      e.st = 2'b00;
        else if ($countones(loaded) == N) e.st = 2'b10;
        else                              e.st = 2'b01;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] ra);
        step(0, 0, 0, 5'd0, 8'h00, 0, 0, ra);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("shadow_a", a, e.a);
                check("rd_data", 256'(rd_data), 256'(e.rd));
                check("ptr", 256'(ptr), 256'(e.ptr));
                check("state", 256'(state), 256'(e.st));
                check("commit_ack", 256'(commit_ack), 256'(e.ack));
            end
        end
    end

    initial begin
        rst = 1; we = 1; auto_inc = 0; addr = 0; data_i = 8'hFF;
        clr = 0; commit = 1; rd_addr = 0;
        rst2 = 1; we2 = 0; auto_inc2 = 0; addr2 = 0; data_i2 = 0;
        clr2 = 0; commit2 = 0; rd_addr2 = 0;
        @(negedge clk);

        // Reset held with write and commit asserted.
        step(1, 1, 0, 5'd5, 8'hFF, 0, 1, 5'd5);
        step(1, 1, 1, 5'd5, 8'hEE, 0, 1, 5'd5);

        // Full stream fill, then commit.
        step(0, 0, 0, 5'd0, 8'h00, 1, 0, 5'd0);
        for (int k = 0; k < N; k++) step(0, 1, 1, 5'd0, 8'(k + 1), 0, 0, 5'(k));
        step(0, 0, 0, 5'd0, 8'h00, 0, 1, 5'd31);
        idle(5'd0);
        idle(5'd0);
        check("stream_a_lo", 256'(a[7:0]), 256'h01);
        check("stream_a_hi", 256'(a[255:248]), 256'h20);

        // Direct write with same-cycle read-back of the same slot.
        step(0, 0, 0, 5'd0, 8'h00, 1, 0, 5'd0);
        step(0, 1, 0, 5'd7, 8'hA5, 0, 0, 5'd7);
        idle(5'd7);
        idle(5'd7);

        // Commit colliding with a write to the same slot.
        step(0, 1, 0, 5'd3, 8'h11, 0, 0, 5'd3);
        step(0, 1, 0, 5'd3, 8'h22, 0, 1, 5'd3);
        step(0, 0, 0, 5'd0, 8'h00, 0, 1, 5'd3);
        idle(5'd3);

        // clr dominates a same-cycle write; also commit together with clr.
        step(0, 1, 1, 5'd0, 8'h55, 1, 0, 5'd0);
        idle(5'd0);
        step(0, 1, 0, 5'd9, 8'h99, 0, 0, 5'd9);
        step(0, 1, 0, 5'd4, 8'h44, 1, 1, 5'd9);
        idle(5'd9);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 100) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
                 5'($urandom), 8'($urandom), ($urandom % 60) == 0,
                 ($urandom % 8) == 0, 5'($urandom));
        end
        idle(5'd0);
        idle(5'd0);
        check("scoreboard_drained", 256'(sb.size()), 256'd0);

        // Parameter sweep: 4 slots of 16 bits, five stream writes wrap onto slot 0.
        rst2 = 0;
        for (int k = 0; k < 5; k++) begin
            we2 = 1; auto_inc2 = 1; data_i2 = 16'h1000 + 16'(k);
            @(negedge clk);
        end
        we2 = 0; auto_inc2 = 0; rd_addr2 = 2'd0;
        @(negedge clk);
        check("sweep_ptr", 256'(ptr2), 256'd1);
        check("sweep_state", 256'(state2), 256'd2);
        check("sweep_slot0", 256'(rd_data2), 256'h1004);
        check("sweep_a", 256'(a2), 256'd0);
        rd_addr2 = 2'd3;
        @(negedge clk);
        check("sweep_slot3", 256'(rd_data2), 256'h1003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
